// File: rtl/reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
//   Shared types and constants for the register-file arbiter.
//   - arb_state_t     : arbiter FSM state (free round-robin vs. locked owner)
//   - ADDR_W_DEFAULT  : register address width shared with the register file
//   - DATA_W          : register data width
//   - lock_cnt_width  : width needed to count up to MAX_LOCK transfers
//   - ptr_width       : width of a requester index (at least 1 bit)
// -----------------------------------------------------------------------------
package reg_arb_pkg;

    localparam int ADDR_W_DEFAULT = 4;
    localparam int DATA_W         = 8;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int lock_cnt_width(input int max_lock);
        return $clog2(max_lock + 1);
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker: returns a one-hot grant for the first
//   set bit of valid_i, searching start_i, start_i+1, ... (mod N).
// Ports
//   valid_i  in   [N]      candidate requests
//   start_i  in   [PTR_W]  index searched first (must be < N)
//   grant_o  out  [N]      one-hot grant, all zero when valid_i is zero
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     valid_i,
    input  logic [PTR_W-1:0] start_i,
    output logic [N-1:0]     grant_o
);

    always_comb begin
        int   idx;
        logic found;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(start_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_arb.sv
// -----------------------------------------------------------------------------
// reg_file_arb
//   Shares one register file (2 clocked read ports, 1 write port) between NREQ
//   requesters. One transfer per cycle, round-robin grant, optional bounded
//   lock so an owner can run an atomic sequence of up to MAX_LOCK transfers.
//   Read data comes back one cycle after the transfer, straight from the
//   register file's clocked read ports.
// Ports
//   clk, reset             clock; synchronous active-high reset
//   req_valid/req_ready    per-requester handshake, ready is one-hot
//   req_lock               keep the grant after this transfer
//   req_we                 transfer also writes rd
//   req_rs/rt/rd           packed per-requester addresses (ADDR_W each)
//   req_wdata              packed per-requester write data (8 bits each)
//   rsp_valid              one-hot, read data belongs to that requester
//   rsp_rs_val/rt_val      shared read-data bus
//   rf_read0/1_addr, rf_write_addr, rf_wen, rf_write_data   to register file
//   rf_read0/1_val         from register file (valid the cycle after address)
// -----------------------------------------------------------------------------
module reg_file_arb
    import reg_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int MAX_LOCK = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ-1:0]          req_lock,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ*ADDR_W-1:0]   req_rs,
    input  logic [NREQ*ADDR_W-1:0]   req_rt,
    input  logic [NREQ*ADDR_W-1:0]   req_rd,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rs_val,
    output logic [DATA_W-1:0]        rsp_rt_val,
    output logic [ADDR_W-1:0]        rf_read0_addr,
    output logic [ADDR_W-1:0]        rf_read1_addr,
    output logic [ADDR_W-1:0]        rf_write_addr,
    output logic                     rf_wen,
    output logic [DATA_W-1:0]        rf_write_data,
    input  logic [DATA_W-1:0]        rf_read0_val,
    input  logic [DATA_W-1:0]        rf_read1_val
);

    localparam int PTR_W = ptr_width(NREQ);
    localparam int CNT_W = lock_cnt_width(MAX_LOCK);

    arb_state_t       state_q;
    logic [PTR_W-1:0] rr_ptr_q;
    logic [PTR_W-1:0] owner_q;
    logic [CNT_W-1:0] lock_cnt_q;
    logic [NREQ-1:0]  rsp_valid_q;

    logic [NREQ-1:0]  rr_grant;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  fire;
    logic             any_fire;
    logic [PTR_W-1:0] fire_idx;
    logic             lock_last;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        return (idx == PTR_W'(NREQ - 1)) ? '0 : idx + PTR_W'(1);
    endfunction

    rr_pick #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .valid_i (req_valid),
        .start_i (rr_ptr_q),
        .grant_o (rr_grant)
    );

    // Grant is suppressed during reset so no transfer (and no rf write) can
    // happen in a reset cycle. While locked only the owner may win.
    always_comb begin
        grant = '0;
        if (!reset) begin
            if (state_q == LOCKED) begin
                grant[owner_q] = req_valid[owner_q];
            end else begin
                grant = rr_grant;
            end
        end
    end

    assign req_ready = grant;
    assign fire      = req_valid & req_ready;
    assign any_fire  = |fire;

    // This transfer is the MAX_LOCK-th of the current lock: release regardless
    // of req_lock.
    assign lock_last = (lock_cnt_q >= CNT_W'(MAX_LOCK - 1));

    // Payload mux; grant is one-hot so at most one iteration hits. Everything
    // reads as zero when nothing is granted.
    always_comb begin
        rf_read0_addr = '0;
        rf_read1_addr = '0;
        rf_write_addr = '0;
        rf_write_data = '0;
        rf_wen        = 1'b0;
        fire_idx      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                rf_read0_addr = req_rs[i*ADDR_W +: ADDR_W];
                rf_read1_addr = req_rt[i*ADDR_W +: ADDR_W];
                rf_write_addr = req_rd[i*ADDR_W +: ADDR_W];
                rf_write_data = req_wdata[i*DATA_W +: DATA_W];
                rf_wen        = req_we[i];
                fire_idx      = PTR_W'(i);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            lock_cnt_q  <= '0;
            rsp_valid_q <= '0;
        end else begin
            rsp_valid_q <= fire;
            unique case (state_q)
                ARB: begin
                    if (any_fire) begin
                        rr_ptr_q <= next_ptr(fire_idx);
                        // With MAX_LOCK==1 a lock could never cover a second
                        // transfer, so the lock is not entered at all.
                        if (req_lock[fire_idx] && (MAX_LOCK > 1)) begin
                            state_q    <= LOCKED;
                            owner_q    <= fire_idx;
                            lock_cnt_q <= CNT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    // Owner idle for a cycle, owner ends the lock, or the
                    // transfer budget is spent: hand back to round-robin.
                    if (!req_valid[owner_q] || !req_lock[owner_q] || lock_last) begin
                        state_q    <= ARB;
                        rr_ptr_q   <= next_ptr(owner_q);
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= lock_cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Response of the transfer one cycle earlier; masked while reset is held.
    assign rsp_valid  = rsp_valid_q & {NREQ{~reset}};
    assign rsp_rs_val = rf_read0_val;
    assign rsp_rt_val = rf_read1_val;

endmodule

// File: tb/tb_reg_file_arb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_arb
//   Self-checking bench for reg_file_arb with a behavioural register file
//   (clocked reads, write on posedge). A transfer-level reference model
//   predicts grants, register-file outputs and responses every cycle.
// -----------------------------------------------------------------------------
module tb_reg_file_arb;

    localparam int NREQ     = 2;
    localparam int ADDR_W   = 4;
    localparam int MAX_LOCK = 8;
    localparam int NREG     = 2 ** ADDR_W;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req_valid, req_ready, req_lock, req_we, rsp_valid;
    logic [NREQ*ADDR_W-1:0] req_rs, req_rt, req_rd;
    logic [NREQ*8-1:0]      req_wdata;
    logic [7:0]             rsp_rs_val, rsp_rt_val;
    logic [ADDR_W-1:0]      rf_read0_addr, rf_read1_addr, rf_write_addr;
    logic                   rf_wen;
    logic [7:0]             rf_write_data, rf_read0_val, rf_read1_val;

    always #5 clk = ~clk;

    reg_file_arb #(
        .NREQ     (NREQ),
        .ADDR_W   (ADDR_W),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_lock      (req_lock),
        .req_we        (req_we),
        .req_rs        (req_rs),
        .req_rt        (req_rt),
        .req_rd        (req_rd),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rs_val    (rsp_rs_val),
        .rsp_rt_val    (rsp_rt_val),
        .rf_read0_addr (rf_read0_addr),
        .rf_read1_addr (rf_read1_addr),
        .rf_write_addr (rf_write_addr),
        .rf_wen        (rf_wen),
        .rf_write_data (rf_write_data),
        .rf_read0_val  (rf_read0_val),
        .rf_read1_val  (rf_read1_val)
    );

    // Behavioural register file: clocked read returns the pre-write value.
    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 13 + 5);
    endfunction

    logic [7:0] rf_mem [NREG];
    logic       rf_fill;

    always @(posedge clk) begin
        if (rf_fill) begin
            for (int i = 0; i < NREG; i++) rf_mem[i] <= init_val(i);
        end else if (rf_wen) begin
            rf_mem[rf_write_addr] <= rf_write_data;
        end
        rf_read0_val <= rf_mem[rf_read0_addr];
        rf_read1_val <= rf_mem[rf_read1_addr];
    end

    // Reference model state (transfer level).
    int              n_tests = 0;
    int              n_fail  = 0;
    int              m_ptr, m_owner, m_cnt;
    bit              m_locked;
    logic [7:0]      m_mem [NREG];
    logic [NREQ-1:0] exp_rsp_valid;
    logic [7:0]      exp_rs, exp_rt;
    int              last_g;
    logic [NREQ-1:0] last_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic l, input logic w,
                           input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt,
                           input logic [ADDR_W-1:0] rd, input logic [7:0] wd);
        req_valid[i]                 = v;
        req_lock[i]                  = l;
        req_we[i]                    = w;
        req_rs[i*ADDR_W +: ADDR_W]   = rs;
        req_rt[i*ADDR_W +: ADDR_W]   = rt;
        req_rd[i*ADDR_W +: ADDR_W]   = rd;
        req_wdata[i*8 +: 8]          = wd;
    endtask

    task automatic set_rand(input int i, input bit allow_lock);
        set_req(i, ($urandom_range(0, 9) < 7), allow_lock && ($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom), 8'($urandom));
    endtask

    // One clock: called just after a posedge with inputs already applied.
    // Checks combinational outputs and the pending response mid-cycle, then
    // advances the model across the next posedge.
    task automatic step(input string tag);
        int          g;
        logic [63:0] exp_bus;
        #3;
        g = -1;
        if (!reset) begin
            if (m_locked) begin
                if (req_valid[m_owner]) g = m_owner;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    int j = (m_ptr + k) % NREQ;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
        end
        exp_bus = '0;
        if (g >= 0) begin
            exp_bus = {44'd0, req_rs[g*ADDR_W +: ADDR_W], req_rt[g*ADDR_W +: ADDR_W],
                       req_rd[g*ADDR_W +: ADDR_W], req_wdata[g*8 +: 8]};
        end
        last_ready = req_ready;
        check({tag, "_ready"}, req_ready, (g >= 0) ? (NREQ'(1) << g) : '0);
        check({tag, "_wen"}, rf_wen, (g >= 0) ? req_we[g] : 1'b0);
        check({tag, "_rfbus"}, {rf_read0_addr, rf_read1_addr, rf_write_addr, rf_write_data}, exp_bus);
        check({tag, "_rspv"}, rsp_valid, reset ? '0 : exp_rsp_valid);
        if (!reset && exp_rsp_valid != '0) begin
            check({tag, "_rspdata"}, {rsp_rs_val, rsp_rt_val}, {exp_rs, exp_rt});
        end
        @(posedge clk);
        if (reset) begin
            m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
            exp_rsp_valid = '0;
        end else begin
            exp_rsp_valid = (g >= 0) ? (NREQ'(1) << g) : '0;
            if (g >= 0) begin
                exp_rs = m_mem[req_rs[g*ADDR_W +: ADDR_W]];
                exp_rt = m_mem[req_rt[g*ADDR_W +: ADDR_W]];
                if (req_we[g]) m_mem[req_rd[g*ADDR_W +: ADDR_W]] = req_wdata[g*8 +: 8];
                if (m_locked) begin
                    m_cnt++;
                    if (!req_lock[g] || m_cnt >= MAX_LOCK) begin
                        m_locked = 0;
                        m_ptr    = (g + 1) % NREQ;
                    end
                end else begin
                    m_ptr = (g + 1) % NREQ;
                    if (req_lock[g] && MAX_LOCK > 1) begin
                        m_locked = 1; m_owner = g; m_cnt = 1;
                    end
                end
            end else if (m_locked) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % NREQ;
            end
        end
        last_g = g;
        #1;
    endtask

    initial begin
        int n0;
        bit done;

        for (int i = 0; i < NREG; i++) m_mem[i] = init_val(i);
        m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 0;
        exp_rsp_valid = '0; exp_rs = '0; exp_rt = '0;
        last_g = -1; last_ready = '0;
        req_valid = '0; req_lock = '0; req_we = '0;
        req_rs = '0; req_rt = '0; req_rd = '0; req_wdata = '0;
        reset = 1'b1;
        rf_fill = 1'b1;
        @(posedge clk); #1;

        // Reset state: nothing granted, rf bus zero, no response.
        step("rst0");
        set_req(0, 1, 0, 1, 4'd2, 4'd4, 4'd2, 8'h11);
        step("rst1");
        rf_fill = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step("idle");

        // 1: write r3 returns old value, next read returns new value.
        set_req(0, 1, 0, 1, 4'd3, 4'd3, 4'd3, 8'h5A);
        step("t1_wr");
        check("t1_old_rv", rsp_valid, 2'b01);
        check("t1_old_val", rsp_rs_val, 8'h2C);
        set_req(0, 1, 0, 0, 4'd3, 4'd3, 4'd0, 8'h00);
        step("t1_rd");
        check("t1_new_rv", rsp_valid, 2'b01);
        check("t1_new_val", rsp_rs_val, 8'h5A);
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        set_req(1, 1, 0, 0, 4'd3, 4'd1, 4'd0, 8'h00);
        step("t1_r1");
        set_req(1, 0, 0, 0, 0, 0, 0, 0);

        // 2: both valid 6 cycles, alternating grants.
        set_rand(0, 0); req_valid[0] = 1'b1;
        set_rand(1, 0); req_valid[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step("t2");
            check("t2_grant", last_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (last_g >= 0) begin
                set_rand(last_g, 0);
                req_valid[last_g] = 1'b1;
            end
        end
        set_req(1, 0, 0, 0, 0, 0, 0, 0);
        step("t2_tail");
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        step("t2_idle");

        // 3: req1 locks 3 transfers while req0 waits.
        set_req(0, 1, 0, 0, 4'd7, 4'd8, 4'd0, 8'h00);
        set_req(1, 1, 1, 1, 4'd9, 4'd3, 4'd9, 8'hC3);
        step("t3_a");
        check("t3_a_grant", last_ready, 2'b10);
        set_req(1, 1, 1, 0, 4'd9, 4'd10, 4'd0, 8'h00);
        step("t3_b");
        check("t3_b_grant", last_ready, 2'b10);
        set_req(1, 1, 0, 1, 4'd10, 4'd9, 4'd10, 8'h3C);
        step("t3_c");
        check("t3_c_grant", last_ready, 2'b10);
        set_req(1, 0, 0, 0, 0, 0, 0, 0);
        step("t3_d");
        check("t3_d_grant", last_ready, 2'b01);
        set_req(0, 0, 0, 0, 0, 0, 0, 0);

        // 4: req0 holds lock continuously; forced release after MAX_LOCK fires.
        set_req(0, 1, 1, 1, 4'd1, 4'd2, 4'd1, 8'h77);
        step("t4_first");
        n0 = (last_ready == 2'b01) ? 1 : 0;
        set_req(1, 1, 0, 0, 4'd1, 4'd3, 4'd0, 8'h00);
        done = 0;
        for (int k = 0; k < 12; k++) begin
            step("t4");
            if (!done) begin
                if (last_ready == 2'b01) begin
                    n0++;
                end else begin
                    done = 1;
                    check("t4_next_req1", last_ready, 2'b10);
                end
            end
            if (last_ready == 2'b10) set_req(1, 0, 0, 0, 0, 0, 0, 0);
        end
        check("t4_lock_len", n0, MAX_LOCK);
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        step("t4_drop");
        step("t4_idle");

        // 5: owner drops valid while locked; waiting req1 wins next cycle.
        set_req(0, 1, 1, 0, 4'd4, 4'd5, 4'd0, 8'h00);
        step("t5_lock");
        set_req(1, 1, 0, 0, 4'd6, 4'd7, 4'd0, 8'h00);
        step("t5_hold");
        check("t5_hold_grant", last_ready, 2'b01);
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        step("t5_drop");
        check("t5_drop_grant", last_ready, 2'b00);
        step("t5_req1");
        check("t5_req1_grant", last_ready, 2'b10);
        set_req(1, 0, 0, 0, 0, 0, 0, 0);
        step("t5_idle");

        // 6: reset the cycle after a write-fire.
        set_req(0, 1, 1, 1, 4'd5, 4'd6, 4'd5, 8'hA5);
        step("t6_wr");
        set_req(0, 1, 0, 1, 4'd5, 4'd6, 4'd6, 8'hEE);
        set_req(1, 1, 0, 1, 4'd5, 4'd6, 4'd7, 8'hDD);
        reset = 1'b1;
        step("t6_rst");
        reset = 1'b0;
        step("t6_after");
        check("t6_first_grant", last_ready, 2'b01);
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        step("t6_r1");
        set_req(1, 0, 0, 0, 0, 0, 0, 0);
        step("t6_idle");

        // Randomized traffic; payload held until fire, with rare early drops.
        for (int c = 0; c < 300; c++) begin
            reset = (c == 150);
            for (int i = 0; i < NREQ; i++) begin
                if (!(req_valid[i] && last_g != i && $urandom_range(0, 19) != 0)) begin
                    set_rand(i, 1);
                end
            end
            step("rand");
        end
        reset = 1'b0;
        req_valid = '0;
        step("end_a");
        step("end_b");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
